seg_counter_display: RTL

Parametrised N-digit event counter with a multiplexed seven-segment display driver. It counts prescaled clock ticks, or external events, in both binary and BCD. It time-multiplexes the selected representation, hex or decimal, onto one shared segment bus with one-hot digit selects. It sits between the board clock domain and the display pins, and replaces the fixed 4-digit, divider-based counter display.

---
 rtl/seg_counter_pkg.sv | 34 +++
 rtl/seg_counter_display_seg7_encode.sv | 15 +
 rtl/seg_counter_display.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/seg_counter_pkg.sv
// Shared constants and helpers for the seven-segment counter display:
// segment bit positions, the 0-F font, and the BCD digit incrementer.
package seg_counter_pkg;

  localparam int unsigned SEG_W  = 8;
  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_B  = 1;
  localparam int unsigned SEG_C  = 2;
  localparam int unsigned SEG_D  = 3;
  localparam int unsigned SEG_E  = 4;
  localparam int unsigned SEG_F  = 5;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;

  // Active-high patterns; entry n is the glyph for nibble n.
  localparam logic [15:0][SEG_W-1:0] SEG_FONT = {
    8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
    8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
  };

  function automatic logic [SEG_W-1:0] seg_font(input logic [3:0] nib);
    logic [SEG_W-1:0] s;
    s         = SEG_FONT[nib];
    s[SEG_DP] = 1'b0;
    return s;
  endfunction

  // Returns {carry, next_digit} for one decimal digit.
  function automatic logic [4:0] bcd_inc(input logic [3:0] d);
    if (d == 4'd9) return {1'b1, 4'd0};
    return {1'b0, 4'(d + 4'd1)};
  endfunction

endpackage

// File: rtl/seg_counter_display_seg7_encode.sv
// Nibble plus blank flag to an active-high seven-segment pattern.
module seg7_encode
  import seg_counter_pkg::*;
(
  input  logic [3:0]       i_nib,
  input  logic             i_blank,
  output logic [SEG_W-1:0] o_seg
);

  always_comb begin
    o_seg = '0;
    if (!i_blank) o_seg = seg_font(i_nib);
  end

endmodule

// File: rtl/seg_counter_display.sv
// N-digit binary/BCD event counter with a multiplexed seven-segment driver.
// Define SEGCNT_BLANK_EN to blank leading-zero digits (digit 0 always shown).
module seg_counter_display
  import seg_counter_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned TICK_W = 32,
  parameter int unsigned SCAN_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hex,
  input  logic [TICK_W-1:0]     cycle,
  input  logic [SCAN_W-1:0]     segtiming,
  input  logic                  ext_sel,
  input  logic                  ext_evt,
  input  logic                  clear,
  output logic                  debug,
  output logic                  wrap,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     sel,
  output logic [SEG_W-1:0]      seg
);

  localparam int unsigned VAL_W = 4 * DIGITS;
  localparam int unsigned DI_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [TICK_W-1:0] r_pc;
  logic              r_debug;
  logic [VAL_W-1:0]  r_bin;
  logic [VAL_W-1:0]  r_bcd;
  logic              r_roll_bin;
  logic              r_roll_bcd;
  logic              r_wrap;
  logic [SCAN_W-1:0] r_sc;
  logic [DI_W-1:0]   r_di;

  logic              w_tick;
  logic              w_inc;
  logic [VAL_W-1:0]  w_bcd_next;
  logic [DIGITS:0]   w_bcd_cy;
  logic [4:0]        w_dig;
  logic              w_bin_max;
  logic              w_bcd_max;
  logic [3:0]        w_nib;
  logic              w_blank;
`ifdef SEGCNT_BLANK_EN
  logic              w_upper_zero;
`endif

  // The >= compare lets a lowered cycle value take effect on the next clock.
  assign w_tick = (r_pc >= cycle);
  assign w_inc  = ext_sel ? ext_evt : w_tick;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc    <= '0;
      r_debug <= 1'b0;
    end else if (w_tick) begin
      r_pc    <= '0;
      r_debug <= ~r_debug;
    end else begin
      r_pc    <= r_pc + TICK_W'(1);
    end
  end

  // Ripple-carry BCD increment; the final carry flags the all-nines state.
  always_comb begin
    w_bcd_next  = r_bcd;
    w_bcd_cy    = '0;
    w_bcd_cy[0] = 1'b1;
    w_dig       = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      w_dig = bcd_inc(r_bcd[4*i +: 4]);
      if (w_bcd_cy[i]) w_bcd_next[4*i +: 4] = w_dig[3:0];
      w_bcd_cy[i+1] = w_bcd_cy[i] & w_dig[4];
    end
  end

  assign w_bcd_max = w_bcd_cy[DIGITS];
  assign w_bin_max = &r_bin;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bin <= '0;
      r_bcd <= '0;
    end else if (clear) begin
      r_bin <= '0;
      r_bcd <= '0;
    end else if (w_inc) begin
      r_bin <= r_bin + VAL_W'(1);
      r_bcd <= w_bcd_next;
    end
  end

  // Rollover is latched first, then reported for the mode selected one clock later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_roll_bin <= 1'b0;
      r_roll_bcd <= 1'b0;
      r_wrap     <= 1'b0;
    end else begin
      r_roll_bin <= !clear && w_inc && w_bin_max;
      r_roll_bcd <= !clear && w_inc && w_bcd_max;
      r_wrap     <= !clear && (hex ? r_roll_bin : r_roll_bcd);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sc <= '0;
      r_di <= '0;
    end else if (r_sc >= segtiming) begin
      r_sc <= '0;
      r_di <= (r_di == DI_W'(DIGITS - 1)) ? '0 : r_di + DI_W'(1);
    end else begin
      r_sc <= r_sc + SCAN_W'(1);
    end
  end

  assign value = hex ? r_bin : r_bcd;
  assign sel   = DIGITS'(1) << r_di;
  assign debug = r_debug;
  assign wrap  = r_wrap;

  // Pick the scanned nibble; walk from the MSD so blanking sees all higher digits.
  always_comb begin
    w_nib   = '0;
    w_blank = 1'b0;
`ifdef SEGCNT_BLANK_EN
    w_upper_zero = 1'b1;
`endif
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
`ifdef SEGCNT_BLANK_EN
      w_upper_zero = w_upper_zero & (value[4*i +: 4] == 4'd0);
`endif
      if (r_di == DI_W'(i)) begin
        w_nib = value[4*i +: 4];
`ifdef SEGCNT_BLANK_EN
        w_blank = (i != 0) && w_upper_zero;
`endif
      end
    end
  end

  seg7_encode u_seg7_encode (
    .i_nib   (w_nib),
    .i_blank (w_blank),
    .o_seg   (seg)
  );

endmodule
